// File: rtl/uart_rx_fsm.sv
// UART receiver: 8 data bits MSB first, even parity, one stop bit.
// Two-flop synchronized input, mid-bit sampling timed from the start edge.
module uart_rx_fsm #(
    parameter int BAUD_BIT = 1667,
    parameter int HALF_BIT = 833
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam logic [12:0] BIT_LAST  = 13'(BAUD_BIT - 1);
    localparam logic [12:0] HALF_LAST = 13'(HALF_BIT - 1);

    state_t      state;
    state_t      state_next;
    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    logic        fall;
    logic [12:0] clk_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        par_bad;
    logic        sample;
    logic        tick_full;
    logic        tick_half;

    // Synchronizer flops come out of reset high so releasing reset is not a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall      = rx_prev & ~rx_s;
    assign tick_full = (clk_cnt == BIT_LAST);
    assign tick_half = (clk_cnt == HALF_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick_half) begin
                    sample     = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_full) begin
                    sample = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (tick_full) begin
                    sample     = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught.
                if (tick_full) begin
                    sample     = 1'b1;
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_cnt <= '0;
        end else if ((state_next != state) || sample || (state == IDLE) || (state == BREAK)) begin
            clk_cnt <= '0;
        end else begin
            clk_cnt <= clk_cnt + 13'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_bad    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                START: begin
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {shift_reg[6:0], rx_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end
                PARITY: begin
                    if (sample) begin
                        par_bad <= rx_s ^ (^shift_reg);
                    end
                end
                STOP: begin
                    if (sample) begin
                        rx_data    <= shift_reg;
                        rx_valid   <= 1'b1;
                        parity_err <= par_bad;
                        frame_err  <= ~rx_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm with a shortened bit period.
module tb_uart_rx_fsm;

    localparam int B = 160;
    localparam int H = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_valid = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         due;
    } exp_t;

    exp_t sb[$];

    uart_rx_fsm #(.BAUD_BIT(B), .HALF_BIT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output side of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rx_valid) begin
            exp_t e;
            n_valid++;
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
                chk("latency", cyc, e.due);
            end
        end
        prev_valid <= rx_valid;
    end

    // nbits < 11 truncates the frame; push_exp=0 for frames that must produce nothing.
    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop,
                              input int nbits, input bit push_exp);
        logic bitv [11];
        exp_t e;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[1+i] = d[7-i];
        bitv[9]  = (^d) ^ par_flip;
        bitv[10] = stop;
        @(posedge clk);
        #1;
        if (push_exp) begin
            e.data = d;
            e.perr = par_flip;
            e.ferr = ~stop;
            e.due  = cyc + 3 + H + 10 * B;
            sb.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            rx_in = bitv[i];
            repeat (B) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_flags", {28'd0, rx_valid, parity_err, frame_err, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Clean frame
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("idle_after_a5", {31'd0, busy}, 32'd0);

        // Parity error, flag hold, then clear
        send_frame(8'h3C, 1'b1, 1'b1, 11, 1'b1);
        repeat (B) @(posedge clk);
        #1;
        chk("perr_hold", {31'd0, parity_err}, 32'd1);
        send_frame(8'h3C, 1'b0, 1'b1, 11, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("perr_cleared", {31'd0, parity_err}, 32'd0);

        // Framing error followed by a long break
        send_frame(8'h81, 1'b0, 1'b0, 11, 1'b1);
        repeat (5000) @(posedge clk);
        #1;
        chk("busy_in_break", {31'd0, busy}, 32'd1);
        chk("ferr_hold", {31'd0, frame_err}, 32'd1);
        rx_in = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_after_break", {31'd0, busy}, 32'd0);

        // Glitch shorter than half a bit
        rx_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_glitch", {31'd0, busy}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (B) @(posedge clk);
        #1;
        chk("busy_after_glitch", {31'd0, busy}, 32'd0);

        // Back-to-back frames, no gap
        send_frame(8'h00, 1'b0, 1'b1, 11, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 11, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        // Reset during data bit 4 of 0x55
        send_frame(8'h55, 1'b0, 1'b1, 5, 1'b0);
        repeat (H / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_flags", {28'd0, rx_valid, parity_err, frame_err, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1);
        repeat (20) @(posedge clk);
        #1;

        chk("valid_count", n_valid, 32'd7);
        chk("pending", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
